// File: rtl/ipf_pkg.sv
// Shared definitions for the IPF stimulus feeder: command encodings,
// sequencer state encoding and default widths.
package ipf_pkg;

  localparam int IPF_DATA_W = 64;
  localparam int IPF_AW     = 16;

  localparam logic [2:0] CTRL_IDLE  = 3'd0;
  localparam logic [2:0] CTRL_START = 3'd1;
  localparam logic [2:0] CTRL_NEXT  = 3'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_I  = 3'd1,
    LD_W  = 3'd2,
    GO    = 3'd3,
    COMP  = 3'd4,
    NXT   = 3'd5,
    FIN   = 3'd6,
    DONE  = 3'd7
  } ipf_state_e;

  // States in which a raised finish cuts the run short.
  function automatic logic is_abortable(input ipf_state_e s);
    return (s == LD_I) || (s == LD_W) || (s == GO) || (s == COMP) || (s == NXT);
  endfunction

endpackage

// File: rtl/ipf_wrap_cnt.sv
// Modulo-N up-counter with synchronous clear and count enable.
module ipf_wrap_cnt #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LAST_V = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear beats enable; the count folds back to zero after N-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST_V) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ipf_feeder.sv
// Stimulus sequencer in front of IPF: streams image and weight words out
// of two synchronous ROMs and issues the START/NEXT commands.
//
// IPF-side handshake: there is no ready. i_valid/w_valid mark the cycle in
// which i_data/w_data carry a word; data is forced to zero when its valid
// is low. ctrl is a one-cycle command pulse and never coincides with a
// valid. The whole sequence is open-loop; only finish can cut it short.
module ipf_feeder
  import ipf_pkg::*;
#(
  parameter int DATA_W   = IPF_DATA_W,
  parameter int I_WORDS  = 8,
  parameter int W_WORDS  = 4,
  parameter int W_SETS   = 2,
  parameter int W_DEPTH  = 8,
  parameter int N_TILE   = 8,
  parameter int COMP_CYC = 32,
  parameter int AW       = IPF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     i_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [AW-1:0]     w_raddr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic [2:0]        ctrl,
  input  logic              finish,
  output logic [2:0]        dbg_state
);

  localparam int IWC_W = (I_WORDS  > 1) ? $clog2(I_WORDS)  : 1;
  localparam int WWC_W = (W_WORDS  > 1) ? $clog2(W_WORDS)  : 1;
  localparam int WA_W  = (W_DEPTH  > 1) ? $clog2(W_DEPTH)  : 1;
  localparam int CC_W  = (COMP_CYC > 1) ? $clog2(COMP_CYC) : 1;
  localparam int SC_W  = (W_SETS   > 1) ? $clog2(W_SETS)   : 1;
  localparam int TC_W  = (N_TILE   > 1) ? $clog2(N_TILE)   : 1;

  ipf_state_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        i_valid_q, i_valid_d;
  logic        w_valid_q, w_valid_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [AW-1:0] i_addr_q, i_addr_d;

  logic start_acc;
  logic abort;

  logic [IWC_W-1:0] i_word;
  logic [WWC_W-1:0] w_word;
  logic [WA_W-1:0]  w_addr;
  logic [CC_W-1:0]  comp_cnt;
  logic [SC_W-1:0]  set_cnt;
  logic [TC_W-1:0]  tile_cnt;

  logic i_word_last, w_word_last, comp_last, set_last, tile_last;

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  assign abort     = finish && is_abortable(state_q);

  assign i_word_last = (i_word   == IWC_W'(I_WORDS  - 1));
  assign w_word_last = (w_word   == WWC_W'(W_WORDS  - 1));
  assign comp_last   = (comp_cnt == CC_W'(COMP_CYC - 1));
  assign set_last    = (set_cnt  == SC_W'(W_SETS   - 1));
  assign tile_last   = (tile_cnt == TC_W'(N_TILE   - 1));

  // Every counter restarts on an accepted start; the weight address is
  // otherwise free-running modulo W_DEPTH across sets and tiles.
  ipf_wrap_cnt #(.N(I_WORDS), .W(IWC_W)) u_i_word (
    .clk(clk), .rst(rst), .clr(start_acc),
    .en((state_q == LD_I) && !abort), .cnt(i_word));

  ipf_wrap_cnt #(.N(W_WORDS), .W(WWC_W)) u_w_word (
    .clk(clk), .rst(rst), .clr(start_acc),
    .en((state_q == LD_W) && !abort), .cnt(w_word));

  ipf_wrap_cnt #(.N(W_DEPTH), .W(WA_W)) u_w_addr (
    .clk(clk), .rst(rst), .clr(start_acc),
    .en((state_q == LD_W) && !abort), .cnt(w_addr));

  ipf_wrap_cnt #(.N(COMP_CYC), .W(CC_W)) u_comp (
    .clk(clk), .rst(rst), .clr(start_acc),
    .en((state_q == COMP) && !abort), .cnt(comp_cnt));

  ipf_wrap_cnt #(.N(W_SETS), .W(SC_W)) u_set (
    .clk(clk), .rst(rst), .clr(start_acc),
    .en((state_q == NXT) && !abort), .cnt(set_cnt));

  ipf_wrap_cnt #(.N(N_TILE), .W(TC_W)) u_tile (
    .clk(clk), .rst(rst), .clr(start_acc),
    .en((state_q == NXT) && !abort && set_last), .cnt(tile_cnt));

  // Next state, image address and the output stage one cycle behind the
  // state that issued the address or command.
  always_comb begin
    state_d  = state_q;
    i_addr_d = i_addr_q;

    if (start_acc) begin
      i_addr_d = '0;
    end else if ((state_q == LD_I) && !abort) begin
      i_addr_d = i_addr_q + 1'b1;
    end

    case (state_q)
      IDLE:    if (start) state_d = LD_I;
      LD_I:    if (i_word_last) state_d = LD_W;
      LD_W:    if (w_word_last) state_d = GO;
      GO:      state_d = COMP;
      COMP:    if (comp_last) state_d = NXT;
      NXT: begin
        if (!set_last) begin
          state_d = LD_W;
        end else if (!tile_last) begin
          state_d = LD_I;
        end else begin
          state_d = FIN;
        end
      end
      FIN:     if (finish) state_d = DONE;
      DONE:    if (start) state_d = LD_I;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = DONE;
    end

    i_valid_d = (state_q == LD_I) && !abort;
    w_valid_d = (state_q == LD_W) && !abort;
    ctrl_d    = CTRL_IDLE;
    if (!abort) begin
      if (state_q == GO) begin
        ctrl_d = CTRL_START;
      end else if (state_q == NXT) begin
        ctrl_d = CTRL_NEXT;
      end
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_addr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      i_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
      ctrl_q    <= CTRL_IDLE;
    end else begin
      state_q   <= state_d;
      i_addr_q  <= i_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      i_valid_q <= i_valid_d;
      w_valid_q <= w_valid_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign i_raddr   = i_addr_q;
  assign w_raddr   = AW'(w_addr);
  assign i_valid   = i_valid_q;
  assign w_valid   = w_valid_q;
  assign i_data    = i_valid_q ? i_rdata : '0;
  assign w_data    = w_valid_q ? w_rdata : '0;
  assign ctrl      = ctrl_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ipf_feeder.sv
// Directed bench for ipf_feeder with behavioural image/weight ROMs.
module tb_ipf_feeder;

  localparam int DW = 64;
  localparam int AW = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst, start, finish;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          busy, done, i_valid, w_valid;
  logic [AW-1:0] i_raddr, w_raddr;
  logic [DW-1:0] i_rdata, w_rdata, i_data, w_data;
  logic [2:0]    ctrl, dbg_state;

  ipf_feeder dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .i_raddr(i_raddr), .i_rdata(i_rdata), .w_raddr(w_raddr), .w_rdata(w_rdata),
    .i_valid(i_valid), .i_data(i_data), .w_valid(w_valid), .w_data(w_data),
    .ctrl(ctrl), .finish(finish), .dbg_state(dbg_state)
  );

  // Pattern ROMs: image word k = k, weight word k = 0x100 + k.
  always @(posedge clk) begin
    i_rdata <= 64'(i_raddr);
    w_rdata <= 64'h100 + 64'(w_raddr);
  end

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w_q[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference timeline relative to the start cycle (rel 0), default
  // parameters, no finish before the end of the run.
  function automatic logic [132:0] exp_at(input int rel);
    int r, tile, p, q, set_i, s;
    logic iv, wv;
    logic [2:0] c;
    logic [63:0] id, wd;
    iv = 1'b0; wv = 1'b0; c = 3'd0; id = '0; wd = '0;
    if (rel >= 2 && rel < 674) begin
      r = rel - 2;
      tile = r / 84;
      p = r % 84;
      if (p < 8) begin
        iv = 1'b1;
        id = 64'(tile * 8 + p);
      end else begin
        q = p - 8;
        set_i = q / 38;
        s = q % 38;
        if (s < 4) begin
          wv = 1'b1;
          wd = 64'h100 + 64'((tile * 8 + set_i * 4 + s) % 8);
        end else if (s == 4) begin
          c = 3'd1;
        end else if (s == 37) begin
          c = 3'd2;
        end
      end
    end
    return {iv, wv, c, id, wd};
  endfunction

  // Run bookkeeping written by the driver
  int start_cyc = 0;
  int run_id = 0;
  bit model_en = 1'b0;
  int model_lim = 0;

  // Monitor state
  int seen_id = 0;
  int iv_t[$];
  logic [DW-1:0] iv_d[$];
  logic [DW-1:0] wv_d[$];
  int c1_t[$];
  int c2_t[$];
  int overlap, gate_err, model_err, done_rise, busy_fall;
  bit prev_done, prev_busy;
  logic [2:0] st672, st673;

  // Sample DUT outputs mid-cycle; restart bookkeeping on each new run.
  always @(negedge clk) begin
    int rel;
    logic [132:0] e;
    if (run_id != seen_id) begin
      seen_id = run_id;
      iv_t.delete(); iv_d.delete(); wv_d.delete(); c1_t.delete(); c2_t.delete();
      overlap = 0; gate_err = 0; model_err = 0; done_rise = -1; busy_fall = -1;
      prev_done = 1'b1; prev_busy = 1'b0; st672 = 3'd0; st673 = 3'd0;
    end
    rel = cyc - start_cyc;
    if (i_valid) begin iv_t.push_back(rel); iv_d.push_back(i_data); end
    if (w_valid) wv_d.push_back(w_data);
    if (ctrl == 3'd1) c1_t.push_back(rel);
    if (ctrl == 3'd2) c2_t.push_back(rel);
    if (ctrl != 3'd0 && (i_valid || w_valid)) overlap++;
    if ((!i_valid && i_data != '0) || (!w_valid && w_data != '0)) gate_err++;
    if (done && !prev_done && done_rise < 0) done_rise = rel;
    prev_done = done;
    if (!busy && prev_busy && busy_fall < 0) busy_fall = rel;
    prev_busy = busy;
    if (rel == 672) st672 = dbg_state;
    if (rel == 673) st673 = dbg_state;
    if (model_en && rel <= model_lim) begin
      e = exp_at(rel);
      if ({i_valid, w_valid, ctrl, i_data, w_data} !== e) model_err++;
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_rel(input int r);
    while (cyc < start_cyc + r) step(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    run_id++;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back(64'(k));
    for (int k = 0; k < 8; k++)  exp_w_q.push_back(64'h100 + 64'(k));
    for (int k = 0; k < 4; k++)  exp_w_q.push_back(64'h100 + 64'(k));

    // Reset state
    step(3);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_i_valid", 64'(i_valid), 64'd0);
    check("rst_w_valid", 64'(w_valid), 64'd0);
    check("rst_i_data", i_data, 64'd0);
    check("rst_w_data", w_data, 64'd0);
    check("rst_ctrl", 64'(ctrl), 64'd0);
    check("rst_i_raddr", 64'(i_raddr), 64'd0);
    check("rst_w_raddr", 64'(w_raddr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    step(1);
    rst = 1'b0;
    step(2);

    // Full run, finish raised 5 cycles after the last NEXT (rel 673)
    model_en = 1'b1; model_lim = 690;
    pulse_start();
    at_rel(678);
    finish = 1'b1;
    step(1);
    finish = 1'b0;
    at_rel(691);
    model_en = 1'b0;
    check("full_timeline_errs", 64'(model_err), 64'd0);
    check("first_i_valid_rel", 64'(iv_t[0]), 64'd2);
    for (int k = 0; k < 8; k++)
      check($sformatf("t0_i_data[%0d]", k), iv_d[k], exp_q[k]);
    for (int k = 0; k < 8; k++)
      check($sformatf("t0_w_data[%0d]", k), wv_d[k], exp_w_q[k]);
    // START lands on the 13th cycle counting the first i_valid as cycle 1.
    check("ctrl1_after_first_iv", 64'(c1_t[0] - iv_t[0]), 64'd12);
    check("ctrl2_after_ctrl1", 64'(c2_t[0] - c1_t[0]), 64'd33);
    check("t1_first_i_valid_rel", 64'(iv_t[8]), 64'd86);
    for (int k = 8; k < 16; k++)
      check($sformatf("t1_i_data[%0d]", k), iv_d[k], exp_q[k]);
    for (int k = 8; k < 12; k++)
      check($sformatf("t1_w_data[%0d]", k), wv_d[k], exp_w_q[k]);
    check("i_valid_count", 64'(iv_d.size()), 64'd64);
    check("w_valid_count", 64'(wv_d.size()), 64'd64);
    check("ctrl1_count", 64'(c1_t.size()), 64'd16);
    check("ctrl2_count", 64'(c2_t.size()), 64'd16);
    check("last_ctrl2_rel", 64'(c2_t[15]), 64'd673);
    check("state_rel672_nxt", 64'(st672), 64'd5);
    check("state_rel673_fin", 64'(st673), 64'd6);
    check("done_rise_rel", 64'(done_rise), 64'd679);
    check("busy_fall_rel", 64'(busy_fall), 64'd679);
    check("ctrl_valid_overlap", 64'(overlap), 64'd0);
    check("data_gating_errs", 64'(gate_err), 64'd0);

    // Restart from DONE, then abort with finish on the 3rd weight word
    pulse_start();
    @(negedge clk);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_done", 64'(done), 64'd0);
    at_rel(12);
    finish = 1'b1;
    step(1);
    finish = 1'b0;
    @(negedge clk);
    check("abort_done", 64'(done), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_w_valid", 64'(w_valid), 64'd0);
    at_rel(60);
    check("abort_i_valid_count", 64'(iv_d.size()), 64'd8);
    check("abort_w_valid_count", 64'(wv_d.size()), 64'd3);
    check("abort_ctrl_pulses", 64'(c1_t.size() + c2_t.size()), 64'd0);
    check("abort_done_rise_rel", 64'(done_rise), 64'd13);

    // Reset in the middle of COMP, then a clean replay
    pulse_start();
    at_rel(20);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    check("midrst_busy_done", 64'({busy, done}), 64'd0);
    check("midrst_valid_ctrl", 64'({i_valid, w_valid, ctrl}), 64'd0);
    check("midrst_data", i_data | w_data, 64'd0);
    check("midrst_addr", 64'({i_raddr, w_raddr}), 64'd0);
    step(1);
    rst = 1'b0;
    step(2);
    model_en = 1'b1; model_lim = 100;
    pulse_start();
    at_rel(101);
    model_en = 1'b0;
    check("replay_first_i_data", iv_d[0], 64'h0);
    check("replay_first_w_data", wv_d[0], 64'h100);
    check("replay_timeline_errs", 64'(model_err), 64'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);

    // start pulsed during LD_W (rel 9..12) must not disturb the sequence
    model_en = 1'b1; model_lim = 130;
    pulse_start();
    at_rel(10);
    start = 1'b1;
    step(1);
    start = 1'b0;
    at_rel(131);
    model_en = 1'b0;
    check("busy_start_timeline_errs", 64'(model_err), 64'd0);
    check("busy_start_set1_w_data", wv_d[4], 64'h104);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);

    // start together with rst: stays idle
    rst = 1'b1; start = 1'b1;
    step(1);
    rst = 1'b0; start = 1'b0;
    step(3);
    @(negedge clk);
    check("rst_start_state", 64'(dbg_state), 64'd0);
    check("rst_start_busy", 64'(busy), 64'd0);
    check("rst_start_i_valid", 64'(i_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
